count_down_timer: RTL and testbench
===================================

# count_down_timer

Single-digit seconds countdown timer driven by the 1 Hz game tick. On a start request it loads a preset value, decrements once per tick down to zero, raises `done` and shows the current count on one active-low seven-segment digit. It is instantiated by period-control blocks (e.g. the preliminary period) to time a phase and report its end.

## Interface
Parameters:
- `START_COUNT`, default 9 — value loaded on start; legal range 0..9 (elaboration error otherwise).

Ports:
- `Clk1Hz`  input  1  — the one clock; all state updates on its rising edge.
- `Rst`  input  1  — reset, asynchronous and active-high.
- `start`  input  1  — start/restart request, sampled on `Clk1Hz` rising edge.
- `done`  output  1  — high while the count has expired (DONE state).
- `seg`  output  8  — seven-segment drive, active-low, bit order {dp,g,f,e,d,c,b,a}.

## Operation
- States: IDLE, RUN, DONE. 4-bit `count` register (unsigned, values 0..9 only).
- Reset: state IDLE, count 0, `done` 0, `seg` 8'hFF (blank).
- IDLE: `seg` = 8'hFF. On `start`=1 load count=START_COUNT; go to RUN, or straight to DONE if START_COUNT=0.
- RUN: on each edge with `start`=0, count decrements by 1; the edge that makes count 0 moves to DONE. On `start`=1, count reloads to START_COUNT (restart; decrement suppressed that edge).
- DONE: count holds 0, `done`=1, `seg` shows digit 0. On `start`=1 reload and go to RUN (or stay DONE if START_COUNT=0); otherwise hold indefinitely.
- Count never wraps below 0; no decrement in IDLE or DONE.
- `seg` in RUN/DONE = decoded count, dp off (bit7=1). Codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
- `done` is registered; `seg` is combinational from registered state and count (glitch-free at 1 Hz).

## Timing
- Start latency: count=START_COUNT visible immediately after the edge sampling `start`.
- Expiry: START_COUNT edges after the start edge (with `start` low), count=0, state DONE, `done`=1 — all after the same edge.
- `done` falls on the edge that samples `start`=1 (unless START_COUNT=0) and after `Rst`.
- `start` held high across several edges keeps reloading; countdown begins on the first edge with `start` low.
- `Rst` asserted mid-count: outputs go to reset values immediately, independent of clock; first edge after release behaves as IDLE.

## Structure
- Shared package: state enum (IDLE/RUN/DONE), `SEG_BLANK`=8'hFF, digit-code constants.
- One sub-module, `seg7_decoder`: 4-bit digit in, 8-bit active-low pattern out; inputs above 9 decode to blank.
- Top holds the state machine, count register and `done` flop.

## Test plan
- Reset then idle: `Rst` pulse, 3 edges with `start`=0 -> `done`=0, `seg`=8'hFF throughout.
- Full countdown, START_COUNT=9: start for one edge -> `seg` 90, 80, F8, …, F9, then C0 with `done`=1 after the 9th following edge; holds C0/1 for 5 more edges.
- Restart while running: start, 4 edges (count 5, `seg` 92), start again -> `seg` 90, expiry 9 edges later.
- Restart from DONE: after expiry, start -> `done`=0, `seg`=90 same edge; counts down again.
- Async reset mid-count at count 3 -> `seg` 8'hFF and `done` 0 before next edge; idle afterwards.
- START_COUNT=0 build: start -> `done`=1, `seg`=C0 after that edge; `start` held high keeps DONE.

Source files
------------

// File: rtl/count_down_timer_pkg.sv
// ============================================================================
// Module      : count_down_timer_pkg
// Description : Shared types and seven-segment constants for count_down_timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_down_timer_pkg;

    localparam int unsigned COUNT_W = 4;
    localparam int unsigned SEG_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Active-low patterns, bit order {dp,g,f,e,d,c,b,a}, decimal point off.
    localparam logic [SEG_W-1:0] SEG_BLANK   = 8'hFF;
    localparam logic [SEG_W-1:0] SEG_DIGIT_0 = 8'hC0;
    localparam logic [SEG_W-1:0] SEG_DIGIT_1 = 8'hF9;
    localparam logic [SEG_W-1:0] SEG_DIGIT_2 = 8'hA4;
    localparam logic [SEG_W-1:0] SEG_DIGIT_3 = 8'hB0;
    localparam logic [SEG_W-1:0] SEG_DIGIT_4 = 8'h99;
    localparam logic [SEG_W-1:0] SEG_DIGIT_5 = 8'h92;
    localparam logic [SEG_W-1:0] SEG_DIGIT_6 = 8'h82;
    localparam logic [SEG_W-1:0] SEG_DIGIT_7 = 8'hF8;
    localparam logic [SEG_W-1:0] SEG_DIGIT_8 = 8'h80;
    localparam logic [SEG_W-1:0] SEG_DIGIT_9 = 8'h90;

endpackage : count_down_timer_pkg

`default_nettype wire

// File: rtl/count_down_timer_seg7_decoder.sv
// ============================================================================
// Module      : seg7_decoder
// Description : BCD digit to active-low seven-segment pattern; >9 is blank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decoder
    import count_down_timer_pkg::*;
(
    input  logic [COUNT_W-1:0] digit_i,
    output logic [SEG_W-1:0]   seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_DIGIT_0;
            4'd1:    seg_o = SEG_DIGIT_1;
            4'd2:    seg_o = SEG_DIGIT_2;
            4'd3:    seg_o = SEG_DIGIT_3;
            4'd4:    seg_o = SEG_DIGIT_4;
            4'd5:    seg_o = SEG_DIGIT_5;
            4'd6:    seg_o = SEG_DIGIT_6;
            4'd7:    seg_o = SEG_DIGIT_7;
            4'd8:    seg_o = SEG_DIGIT_8;
            4'd9:    seg_o = SEG_DIGIT_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule : seg7_decoder

`default_nettype wire

// File: rtl/count_down_timer.sv
// ============================================================================
// Module      : count_down_timer
// Description : Single-digit 1 Hz countdown with done flag and 7-seg display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_down_timer
    import count_down_timer_pkg::*;
#(
    parameter int START_COUNT = 9
) (
    input  logic             Clk1Hz,
    input  logic             Rst,
    input  logic             start,
    output logic             done,
    output logic [SEG_W-1:0] seg
);

    generate
        if (START_COUNT < 0 || START_COUNT > 9) begin : g_bad_start_count
            $error("count_down_timer: START_COUNT must be in 0..9");
        end
    endgenerate

    localparam logic [COUNT_W-1:0] c_LOAD_COUNT = COUNT_W'(START_COUNT);
    // A zero preset expires on the very edge that loads it.
    localparam state_t             c_LOAD_STATE = (START_COUNT == 0) ? ST_DONE : ST_RUN;
    localparam logic               c_LOAD_DONE  = (START_COUNT == 0);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               done_q,  done_d;
    logic [SEG_W-1:0]   dec_seg;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        if (start) begin
            state_d = c_LOAD_STATE;
            count_d = c_LOAD_COUNT;
            done_d  = c_LOAD_DONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    done_d  = 1'b0;
                end
                ST_RUN: begin
                    if (count_q <= 4'd1) begin
                        state_d = ST_DONE;
                        count_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q - 4'd1;
                        done_d  = 1'b0;
                    end
                end
                ST_DONE: begin
                    count_d = '0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk1Hz or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    seg7_decoder u_seg7_decoder (
        .digit_i (count_q),
        .seg_o   (dec_seg)
    );

    assign seg  = (state_q == ST_IDLE) ? SEG_BLANK : dec_seg;
    assign done = done_q;

endmodule : count_down_timer

`default_nettype wire

// File: tb/tb_count_down_timer.sv
// ============================================================================
// Module      : tb_count_down_timer
// Description : Directed scoreboard bench for count_down_timer (presets 9 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_down_timer;

    typedef struct {
        string      tag;
        bit         dut0;
        logic       done;
        logic [7:0] seg;
    } exp_t;

    logic       Clk1Hz = 1'b0;
    logic       Rst    = 1'b1;
    logic       start9 = 1'b0;
    logic       start0 = 1'b0;
    logic       done9, done0;
    logic [7:0] seg9, seg0;

    exp_t       sb_q[$];
    int         n_total  = 0;
    int         n_passed = 0;

    always #5 Clk1Hz = ~Clk1Hz;

    count_down_timer #(.START_COUNT(9)) u_dut9 (
        .Clk1Hz (Clk1Hz),
        .Rst    (Rst),
        .start  (start9),
        .done   (done9),
        .seg    (seg9)
    );

    count_down_timer #(.START_COUNT(0)) u_dut0 (
        .Clk1Hz (Clk1Hz),
        .Rst    (Rst),
        .start  (start0),
        .done   (done0),
        .seg    (seg0)
    );

    function automatic logic [7:0] digit_code(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic expect9(input string tag, input logic d, input logic [7:0] s);
        exp_t e;
        e.tag = tag; e.dut0 = 1'b0; e.done = d; e.seg = s;
        sb_q.push_back(e);
    endtask

    task automatic expect0(input string tag, input logic d, input logic [7:0] s);
        exp_t e;
        e.tag = tag; e.dut0 = 1'b1; e.done = d; e.seg = s;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [8:0] obs;
        logic [8:0] req;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = e.dut0 ? {done0, seg0} : {done9, seg9};
            req = {e.done, e.seg};
            n_total++;
            assert (obs === req) begin
                n_passed++;
            end else begin
                $error("FAIL %s: observed done=%b seg=%h, expected done=%b seg=%h",
                       e.tag, obs[8], obs[7:0], req[8], req[7:0]);
            end
        end
    endtask

    task automatic edge_check();
        @(posedge Clk1Hz);
        #1;
        drain();
    endtask

    initial begin
        // Reset is asynchronous: outputs valid before any clock edge.
        #2;
        expect9("reset9", 1'b0, 8'hFF);
        expect0("reset0", 1'b0, 8'hFF);
        drain();
        @(posedge Clk1Hz);
        #1 Rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            expect9("idle9", 1'b0, 8'hFF);
            expect0("idle0", 1'b0, 8'hFF);
            edge_check();
        end

        // Full countdown from 9.
        start9 = 1'b1;
        expect9("start9", 1'b0, 8'h90);
        edge_check();
        start9 = 1'b0;
        for (int c = 8; c >= 1; c--) begin
            expect9("count9", 1'b0, digit_code(c));
            edge_check();
        end
        expect9("expire9", 1'b1, 8'hC0);
        edge_check();
        for (int i = 0; i < 5; i++) begin
            expect9("hold_done", 1'b1, 8'hC0);
            edge_check();
        end

        // Restart from DONE, then restart while running at count 5.
        start9 = 1'b1;
        expect9("restart_done", 1'b0, 8'h90);
        edge_check();
        start9 = 1'b0;
        for (int c = 8; c >= 5; c--) begin
            expect9("count_pre_restart", 1'b0, digit_code(c));
            edge_check();
        end
        start9 = 1'b1;
        expect9("restart_run", 1'b0, 8'h90);
        edge_check();
        start9 = 1'b0;
        for (int c = 8; c >= 1; c--) begin
            expect9("count_post_restart", 1'b0, digit_code(c));
            edge_check();
        end
        expect9("expire_restart", 1'b1, 8'hC0);
        edge_check();

        // Start held high keeps reloading.
        start9 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect9("start_held", 1'b0, 8'h90);
            edge_check();
        end
        start9 = 1'b0;
        for (int c = 8; c >= 3; c--) begin
            expect9("count_to3", 1'b0, digit_code(c));
            edge_check();
        end

        // Asynchronous reset between edges at count 3.
        Rst = 1'b1;
        #1;
        expect9("async_rst9", 1'b0, 8'hFF);
        expect0("async_rst0", 1'b0, 8'hFF);
        drain();
        #1 Rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect9("idle_after_rst", 1'b0, 8'hFF);
            edge_check();
        end

        // Zero preset expires immediately and stays expired.
        start0 = 1'b1;
        expect0("start0", 1'b1, 8'hC0);
        edge_check();
        for (int i = 0; i < 3; i++) begin
            expect0("start0_held", 1'b1, 8'hC0);
            edge_check();
        end
        start0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect0("hold0", 1'b1, 8'hC0);
            expect9("idle9_late", 1'b0, 8'hFF);
            edge_check();
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule : tb_count_down_timer

`default_nettype wire
